demux1to11_buf: RTL

- Registered 1-to-11 demultiplexer: routes a 32-bit word to one of 11 destination channels chosen by a 4-bit select.
- Each channel has a one-entry output buffer with a valid/ready handshake.
- Sits on the producer side of the datapath and fans one result bus out to 11 consumers; it is the inverse of the 11-input word select.
- Words with an out-of-range select are dropped and flagged.

---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_slot.sv | 32 +++
 rtl/demux1to11_buf.sv | 106 ++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared sizing constants and helpers for the 1-to-11 word demultiplexer.
// Optional build macro: DEMUX1TO11_DROP_CNT_EN (drop counter output on the top level).
package demux_pkg;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 11;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] MAX_SEL = 4'd10;

  function automatic logic [3:0] popcount11(input logic [10:0] vec);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 11; i++) begin
      cnt = cnt + {3'b000, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry channel buffer; a load on the same edge as a pop refills without a bubble.
module demux_slot
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      data_q <= load_data;
    end else if (pop && full_q) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/demux1to11_buf.sv
// Registered 1-to-11 demultiplexer with per-channel one-entry buffers and a sticky drop flag.
// Optional build macro: DEMUX1TO11_DROP_CNT_EN adds drop_cnt, a saturating count of dropped words.
module demux1to11_buf
  import demux_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [3:0]               pending,
`ifdef DEMUX1TO11_DROP_CNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic                     err,
  input  logic                     err_clr
);

  logic [NUM_CH-1:0] fullVec;
  logic [NUM_CH-1:0] loadVec;
  logic [NUM_CH-1:0] fullNext;
  logic [15:0]       fullExt;
  logic [15:0]       readyExt;
  logic              selValid;
  logic              accept;
  logic              drop;
  logic [3:0]        pending_q, pending_d;
  logic              err_q, err_d;

  // Widen to the full select range so selects 11..15 index harmless zeros.
  assign fullExt  = 16'(fullVec);
  assign readyExt = 16'(out_ready);
  assign selValid = (in_sel <= MAX_SEL);
  assign in_ready = !selValid || !fullExt[in_sel] || readyExt[in_sel];
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !selValid;

  for (genvar k = 0; k < NUM_CH; k++) begin : gSlot
    assign loadVec[k] = accept && selValid && (in_sel == SEL_W'(k));

    demux_slot uSlot (
      .clk       (clk),
      .rst       (rst),
      .load      (loadVec[k]),
      .load_data (in_data),
      .pop       (out_ready[k]),
      .full      (fullVec[k]),
      .data      (out_data[k*DATA_W +: DATA_W])
    );
  end

  assign out_valid = fullVec;

  // pending tracks the slots' next state so it lands on the same edge as out_valid.
  always_comb begin
    fullNext  = loadVec | (fullVec & ~out_ready);
    pending_d = popcount11(fullNext);
    err_d     = err_q;
    if (drop) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending = pending_q;
  assign err     = err_q;

`ifdef DEMUX1TO11_DROP_CNT_EN
  logic [7:0] dropCnt_q, dropCnt_d;

  always_comb begin
    dropCnt_d = dropCnt_q;
    if (err_clr) begin
      dropCnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_cnt = dropCnt_q;
`endif

endmodule
